// File: rtl/cpu_bus_mmio_if.sv
// CPU RAM-bus and TX-stream signals shared by the MMIO responder and its
// environment (CPU, blram and the TX consumer).
interface cpu_bus_mmio_if;
  logic        wrEn;
  logic [12:0] addr_toRAM;
  logic [15:0] data_toRAM;
  logic [15:0] data_fromRAM;
  logic        ram_wrEn;
  logic [15:0] ram_data_out;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  // Environment side: CPU drives the bus, blram returns read data,
  // the consumer drives tx_ready.
  modport master (
    output wrEn, addr_toRAM, data_toRAM, ram_data_out, tx_ready,
    input  data_fromRAM, ram_wrEn, tx_data, tx_valid
  );

  // Responder side, as seen by cpu_bus_mmio.
  modport slave (
    input  wrEn, addr_toRAM, data_toRAM, ram_data_out, tx_ready,
    output data_fromRAM, ram_wrEn, tx_data, tx_valid
  );
endinterface

// File: rtl/cpu_bus_mmio.sv
// Memory-mapped I/O responder on the CPU RAM bus. A 16-word window at BASE
// serves a TX FIFO, status, a free-running cycle counter and a scratch
// register; every other address passes straight through to blram. Both paths
// return read data one cycle after the address.
module cpu_bus_mmio #(
  parameter logic [12:0] BASE  = 13'h1FF0,
  parameter int          DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  cpu_bus_mmio_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [3:0] {
    OFF_TXDATA   = 4'd0,
    OFF_STATUS   = 4'd1,
    OFF_CYCLE_LO = 4'd2,
    OFF_CYCLE_HI = 4'd3,
    OFF_SCRATCH  = 4'd4
  } offset_e;

  logic          hit, rd;
  logic [3:0]    offset;
  logic          push, pop, push_ok, ovf_set, ovf_clr;
  logic          empty, full;
  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [6:0]    count7;
  logic          overflow;
  logic [31:0]   cycle;
  logic [15:0]   shadow_hi, scratch;
  logic [15:0]   rdata_next, mmio_rdata_q;
  logic          sel_q;

  assign hit    = (bus.addr_toRAM[12:4] == BASE[12:4]);
  assign offset = bus.addr_toRAM[3:0];
  assign rd     = hit & ~bus.wrEn;

  assign bus.ram_wrEn = bus.wrEn & ~hit;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign count7 = 7'(count);

  assign push    = bus.wrEn & hit & (offset == OFF_TXDATA);
  assign pop     = ~empty & bus.tx_ready;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & ~push_ok;
  assign ovf_clr = bus.wrEn & hit & (offset == OFF_STATUS) & bus.data_toRAM[2];

  // First-word fall-through head; forced to zero while empty so the output
  // never exposes stale or uninitialised storage.
  assign bus.tx_valid = ~empty;
  assign bus.tx_data  = empty ? 16'h0000 : mem[rd_ptr];

  // Read mux for the window, sampled from pre-edge state.
  always_comb begin
    // NOTE: default first so every path assigns rdata_next and no latch is inferred.
    rdata_next = 16'h0000;
    case (offset)
      OFF_STATUS:   rdata_next = {6'b0, count7, overflow, full, empty};
      OFF_CYCLE_LO: rdata_next = cycle[15:0];
      OFF_CYCLE_HI: rdata_next = shadow_hi;
      OFF_SCRATCH:  rdata_next = scratch;
      default:      rdata_next = 16'h0000;
    endcase
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count/pointers define validity.
    if (push_ok) mem[wr_ptr] <= bus.data_toRAM;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Set beats clear if both ever coincide.
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Cycle counter, CYCLE_HI shadow, scratch register and read-data pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle        <= 32'h0;
      shadow_hi    <= 16'h0;
      scratch      <= 16'h0;
      sel_q        <= 1'b0;
      mmio_rdata_q <= 16'h0;
    end else begin
      cycle <= cycle + 32'd1;
      // Capturing the upper half with the lower read keeps LO/HI pairs coherent.
      if (rd && offset == OFF_CYCLE_LO) shadow_hi <= cycle[31:16];
      if (bus.wrEn && hit && offset == OFF_SCRATCH) scratch <= bus.data_toRAM;
      sel_q        <= hit;
      mmio_rdata_q <= rd ? rdata_next : 16'h0000;
    end
  end

  assign bus.data_fromRAM = sel_q ? mmio_rdata_q : bus.ram_data_out;

endmodule

// File: tb/tb_cpu_bus_mmio.sv
// Directed self-checking bench for cpu_bus_mmio with a behavioural blram.
module tb_cpu_bus_mmio;
  logic clk;
  logic rst;
  int   n_asserts = 0;
  int   n_fail    = 0;
  logic [31:0] tb_cyc;
  logic [31:0] e;
  int   guard;

  cpu_bus_mmio_if bus ();

  cpu_bus_mmio #(.BASE(13'h1FF0), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural blram: synchronous write, one-cycle read latency.
  logic [15:0] ram [8192];
  logic [15:0] ram_q;
  always @(posedge clk) begin
    if (bus.ram_wrEn) ram[bus.addr_toRAM] <= bus.data_toRAM;
    ram_q <= ram[bus.addr_toRAM];
  end
  assign bus.ram_data_out = ram_q;

  // Expected cycle-counter value held between edges.
  always @(posedge clk) begin
    if (rst) tb_cyc <= 32'h0;
    else     tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wrEn       = 1'b0;
    bus.addr_toRAM = 13'h0000;
    tick();
  endtask

  task automatic rd(input logic [12:0] a);
    bus.wrEn       = 1'b0;
    bus.addr_toRAM = a;
    tick();
  endtask

  task automatic wr(input logic [12:0] a, input logic [15:0] d);
    bus.wrEn       = 1'b1;
    bus.addr_toRAM = a;
    bus.data_toRAM = d;
    tick();
    bus.wrEn = 1'b0;
  endtask

  task automatic wr_probe(input string tag, input logic [12:0] a, input logic [15:0] d,
                          input logic exp_we);
    bus.wrEn       = 1'b1;
    bus.addr_toRAM = a;
    bus.data_toRAM = d;
    #1;
    check(tag, {31'b0, bus.ram_wrEn}, {31'b0, exp_we});
    tick();
    bus.wrEn = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.wrEn       = 1'b0;
    bus.addr_toRAM = 13'h0000;
    bus.data_toRAM = 16'h0000;
    bus.tx_ready   = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    check("rst_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
    check("rst_tx_data", {16'h0, bus.tx_data}, 32'h0);
    check("rst_passthru", {16'h0, bus.data_fromRAM}, {16'h0, bus.ram_data_out});
    rd(13'h1FF1); check("rst_status", {16'h0, bus.data_fromRAM}, 32'h0001);
    rd(13'h1FF3); check("rst_shadow", {16'h0, bus.data_fromRAM}, 32'h0000);
    rd(13'h1FF4); check("rst_scratch", {16'h0, bus.data_fromRAM}, 32'h0000);

    // Scratch in window, plain RAM outside it
    wr_probe("scratch_ram_we", 13'h1FF4, 16'h1234, 1'b0);
    rd(13'h1FF4); check("scratch_rd", {16'h0, bus.data_fromRAM}, 32'h1234);
    wr_probe("ram_we", 13'h0048, 16'hBEEF, 1'b1);
    rd(13'h0048); check("ram_rd", {16'h0, bus.data_fromRAM}, 32'hBEEF);

    // Unmapped offset and TXDATA read return 0
    wr_probe("off5_ram_we", 13'h1FF5, 16'hFFFF, 1'b0);
    rd(13'h1FF5); check("off5_rd", {16'h0, bus.data_fromRAM}, 32'h0000);
    rd(13'h1FF0); check("txdata_rd", {16'h0, bus.data_fromRAM}, 32'h0000);
    check("txdata_rd_nopush", {31'b0, bus.tx_valid}, 32'h0);

    // Fill past depth with the consumer stalled
    for (int i = 1; i <= 17; i++) wr(13'h1FF0, 16'(i));
    rd(13'h1FF1); check("full_status", {16'h0, bus.data_fromRAM}, 32'h0086);
    check("full_valid", {31'b0, bus.tx_valid}, 32'h1);
    check("full_head", {16'h0, bus.tx_data}, 32'h0001);
    idle();       check("stall_hold", {16'h0, bus.tx_data}, 32'h0001);

    // Overflow clear only on bit2; rejected push sets it again
    wr(13'h1FF1, 16'h0003);
    rd(13'h1FF1); check("clr_bit2_clear", {16'h0, bus.data_fromRAM}, 32'h0086);
    wr(13'h1FF1, 16'h0004);
    rd(13'h1FF1); check("clr_ovf", {16'h0, bus.data_fromRAM}, 32'h0082);
    wr(13'h1FF0, 16'h0018);
    rd(13'h1FF1); check("reject_sets_ovf", {16'h0, bus.data_fromRAM}, 32'h0086);
    wr(13'h1FF1, 16'h0004);
    rd(13'h1FF1); check("clr_ovf2", {16'h0, bus.data_fromRAM}, 32'h0082);

    // Full FIFO: push with simultaneous pop is accepted
    bus.tx_ready = 1'b1;
    #1;
    check("pop1_head", {16'h0, bus.tx_data}, 32'h0001);
    wr(13'h1FF0, 16'hAAAA);
    bus.tx_ready = 1'b0;
    rd(13'h1FF1); check("full_push_pop", {16'h0, bus.data_fromRAM}, 32'h0082);

    // Drain: 2..16 then AAAA, then empty
    bus.tx_ready = 1'b1;
    for (int i = 2; i <= 16; i++) begin
      check("drain_valid", {31'b0, bus.tx_valid}, 32'h1);
      check("drain_data", {16'h0, bus.tx_data}, 32'(i));
      idle();
    end
    check("drain_last", {16'h0, bus.tx_data}, 32'hAAAA);
    idle();
    check("drain_empty_valid", {31'b0, bus.tx_valid}, 32'h0);
    check("drain_empty_data", {16'h0, bus.tx_data}, 32'h0000);
    bus.tx_ready = 1'b0;
    rd(13'h1FF1); check("drain_status", {16'h0, bus.data_fromRAM}, 32'h0001);

    // Mid-operation reset discards queued words
    for (int i = 1; i <= 5; i++) wr(13'h1FF0, 16'(16'h0100 + i));
    rd(13'h1FF1); check("five_status", {16'h0, bus.data_fromRAM}, 32'h0028);
    rst          = 1'b1;
    bus.tx_ready = 1'b1;
    idle();
    rst          = 1'b0;
    bus.tx_ready = 1'b0;
    check("rst2_valid", {31'b0, bus.tx_valid}, 32'h0);
    rd(13'h1FF1); check("rst2_status", {16'h0, bus.data_fromRAM}, 32'h0001);
    wr(13'h1FF0, 16'h0042);
    check("post_rst_valid", {31'b0, bus.tx_valid}, 32'h1);
    check("post_rst_data", {16'h0, bus.tx_data}, 32'h0042);

    // Cycle counter across the 16-bit boundary: shadow prevents tearing
    guard = 0;
    while (tb_cyc != 32'h0000FFFF && guard < 70000) begin
      idle();
      guard++;
    end
    check("cycle_wait_bound", {31'b0, guard < 70000}, 32'h1);
    rd(13'h1FF2); check("cycle_lo_ffff", {16'h0, bus.data_fromRAM}, 32'hFFFF);
    rd(13'h1FF3); check("cycle_hi_shadow", {16'h0, bus.data_fromRAM}, 32'h0000);
    e = tb_cyc;
    rd(13'h1FF2); check("cycle_lo_wrap", {16'h0, bus.data_fromRAM}, {16'h0, e[15:0]});
    rd(13'h1FF3); check("cycle_hi_one", {16'h0, bus.data_fromRAM}, 32'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
